i2c_master_shift_engine: RTL

//  Parametrised successor of the I2C master data path. Executes one bus command at a time
//  (START, WRITE, READ, STOP, REPEAT_START) issued by the master FSM over a valid/ready handshake.

---
 rtl/i2c_master_shift_engine_pkg.sv | 46 ++++
 rtl/i2c_master_shift_engine_if.sv | 43 ++++
 rtl/i2c_master_shift_engine_scl_phase_gen.sv | 49 ++++
 rtl/i2c_master_shift_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_shift_engine_pkg.sv
// i2c_pkg: command codes, engine FSM states and quarter-bit phases.
// Shared by the shift engine and its SCL phase generator.
package i2c_pkg;

   typedef enum logic [2:0] {
      CMD_NOP    = 3'd0,
      CMD_START  = 3'd1,
      CMD_WRITE  = 3'd2,
      CMD_READ   = 3'd3,
      CMD_STOP   = 3'd4,
      CMD_RSTART = 3'd5
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RSTART,
      ST_WRITE,
      ST_READ,
      ST_ACK_RX,
      ST_ACK_TX,
      ST_STOP
   } state_e;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } phase_e;

   localparam int PRESC_MIN = 2;

   // Unknown codes map to IDLE and are treated as a NOP.
   function automatic state_e cmd_to_state(input logic [2:0] cmd);
      case (cmd)
         CMD_START:  return ST_START;
         CMD_WRITE:  return ST_WRITE;
         CMD_READ:   return ST_READ;
         CMD_STOP:   return ST_STOP;
         CMD_RSTART: return ST_RSTART;
         default:    return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/i2c_master_shift_engine_if.sv
// Command handshake and bus lines between control FSM,
// shift engine and pad drivers.
interface i2c_master_shift_engine_if #(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 8
);
   logic [2:0]         cmd_i;
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic [DATA_W-1:0]  data_i;
   logic               ack_bit_i;
   logic [PRESC_W-1:0] prescaler_i;
   logic               sda_i;
   logic               scl_i;
   logic               sda_o;
   logic               scl_o;
   logic [DATA_W-1:0]  data_o;
   logic               ack_o;
   logic               done_o;
   logic               arb_lost_o;
   logic               busy_o;

   modport master (
      output cmd_i, cmd_valid_i, data_i,
      output ack_bit_i, prescaler_i,
      input  cmd_ready_o, data_o, ack_o,
      input  done_o, arb_lost_o, busy_o
   );

   modport slave (
      input  cmd_i, cmd_valid_i, data_i,
      input  ack_bit_i, prescaler_i,
      input  sda_i, scl_i,
      output cmd_ready_o, data_o, ack_o,
      output done_o, arb_lost_o, busy_o,
      output sda_o, scl_o
   );

   modport pad (
      input  sda_o, scl_o,
      output sda_i, scl_i
   );
endinterface

// File: rtl/i2c_master_shift_engine_scl_phase_gen.sv
// i2c_scl_phase_gen: prescaler counter and Q0..Q3 sequencing.
// Build option I2C_CLOCK_STRETCH_EN: hold the counter in Q2 while scl low.
module i2c_scl_phase_gen
   import i2c_pkg::*;
#(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic [PRESC_W-1:0] presc,
   input  logic               scl_line,
   output phase_e             phase,
   output logic               phase_last,
   output logic               slot_last
);
   logic [PRESC_W-1:0] cnt;
   logic               hold;

`ifdef I2C_CLOCK_STRETCH_EN
   assign hold = (phase == Q2) && !scl_line;
`else
   logic unused_scl;
   assign unused_scl = scl_line;
   assign hold = 1'b0;
`endif

   assign phase_last = (cnt == presc - 1'b1) && !hold;
   assign slot_last  = phase_last && (phase == Q3);

   // Count P cycles per phase; rest at Q0 while the engine is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= Q0;
      end else if (!run) begin
         cnt   <= '0;
         phase <= Q0;
      end else if (hold) begin
         cnt   <= cnt;
      end else if (phase_last) begin
         cnt   <= '0;
         phase <= phase_e'(phase + 2'd1);
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_shift_engine.sv
// i2c_master_shift_engine: runs one I2C bus command at a time.
// Build option I2C_CLOCK_STRETCH_EN enables slave clock stretching.
module i2c_master_shift_engine
   import i2c_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 8
) (
   input logic                      i2c_core_clock_i,
   input logic                      reset_bit_i,
   i2c_master_shift_engine_if.slave bus
);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e             state_q;
   state_e             state_d;
   phase_e             phase;
   logic               phase_last;
   logic               slot_last;
   logic               sample;
   logic               cmd_ready;
   logic               accept;
   logic               done_d;
   logic               done_q;
   logic               arb;
   logic               arb_q;
   logic [PRESC_W-1:0] presc_q;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W-1:0]  data_q;
   logic [CW-1:0]      bit_cnt_q;
   logic               last_bit;
   logic               ack_bit_q;
   logic               ack_q;
   logic               idle_sda_q;
   logic               idle_scl_q;
   logic               sda_drv;
   logic               scl_drv;
   logic               scl_hi;

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = bus.cmd_valid_i && cmd_ready;
   assign sample    = (phase == Q2) && phase_last;
   assign last_bit  = (bit_cnt_q == '0);
   assign scl_hi    = (phase == Q2) || (phase == Q3);

   // A driven 1 read back as 0 means another master owns the bus.
   assign arb = (state_q == ST_WRITE) && sample
             && shift_q[DATA_W-1] && !bus.sda_i;

   i2c_scl_phase_gen #(
      .PRESC_W (PRESC_W)
   ) u_phase (
      .clk        (i2c_core_clock_i),
      .rst_n      (reset_bit_i),
      .run        (!cmd_ready),
      .presc      (presc_q),
      .scl_line   (bus.scl_i),
      .phase      (phase),
      .phase_last (phase_last),
      .slot_last  (slot_last)
   );

   // FSM state register.
   always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
      if (!reset_bit_i) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // Next state and completion strobe.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = cmd_to_state(bus.cmd_i);
               done_d  = (state_d == ST_IDLE);
            end
         end
         ST_WRITE: begin
            if (arb)
               state_d = ST_IDLE;
            else if (slot_last && last_bit)
               state_d = ST_ACK_RX;
         end
         ST_READ: begin
            if (slot_last && last_bit)
               state_d = ST_ACK_TX;
         end
         ST_START, ST_RSTART, ST_STOP,
         ST_ACK_RX, ST_ACK_TX: begin
            if (slot_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command latching, shifting, sampling and idle line levels.
   always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
      if (!reset_bit_i) begin
         presc_q    <= PRESC_W'(PRESC_MIN);
         shift_q    <= '0;
         data_q     <= '0;
         bit_cnt_q  <= '0;
         ack_bit_q  <= 1'b1;
         ack_q      <= 1'b1;
         done_q     <= 1'b0;
         arb_q      <= 1'b0;
         idle_sda_q <= 1'b1;
         idle_scl_q <= 1'b1;
      end else begin
         done_q <= done_d;
         arb_q  <= arb;
         if (accept) begin
            presc_q   <= (bus.prescaler_i < PRESC_W'(PRESC_MIN))
                       ? PRESC_W'(PRESC_MIN) : bus.prescaler_i;
            ack_bit_q <= bus.ack_bit_i;
            bit_cnt_q <= CW'(DATA_W - 1);
            if (bus.cmd_i == CMD_WRITE)
               shift_q <= bus.data_i;
         end
         if (state_q == ST_WRITE && slot_last) begin
            shift_q <= shift_q << 1;
         end
         if (state_q == ST_READ && sample) begin
            shift_q <= (shift_q << 1) | DATA_W'(bus.sda_i);
         end
         if ((state_q == ST_WRITE || state_q == ST_READ)
             && slot_last && !last_bit) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
         end
         if (state_q == ST_READ && slot_last && last_bit) begin
            data_q <= shift_q;
         end
         if (state_q == ST_ACK_RX && sample) begin
            ack_q <= bus.sda_i;
         end
         if (arb) begin
            idle_sda_q <= 1'b1;
            idle_scl_q <= 1'b1;
         end else if (slot_last) begin
            case (state_q)
               ST_START, ST_RSTART: begin
                  idle_sda_q <= 1'b0;
                  idle_scl_q <= 1'b0;
               end
               ST_STOP: begin
                  idle_sda_q <= 1'b1;
                  idle_scl_q <= 1'b1;
               end
               ST_ACK_RX, ST_ACK_TX: begin
                  idle_sda_q <= 1'b1;
                  idle_scl_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Line levels per state and quarter phase.
   always_comb begin
      sda_drv = idle_sda_q;
      scl_drv = idle_scl_q;
      case (state_q)
         ST_START: begin
            sda_drv = !scl_hi;
            scl_drv = 1'b1;
         end
         ST_RSTART: begin
            sda_drv = !scl_hi;
            scl_drv = (phase != Q0);
         end
         ST_STOP: begin
            sda_drv = scl_hi;
            scl_drv = (phase != Q0);
         end
         ST_WRITE: begin
            sda_drv = shift_q[DATA_W-1];
            scl_drv = scl_hi;
         end
         ST_READ, ST_ACK_RX: begin
            sda_drv = 1'b1;
            scl_drv = scl_hi;
         end
         ST_ACK_TX: begin
            sda_drv = ack_bit_q;
            scl_drv = scl_hi;
         end
         default: ;
      endcase
   end

   assign bus.sda_o       = sda_drv;
   assign bus.scl_o       = scl_drv;
   assign bus.data_o      = data_q;
   assign bus.ack_o       = ack_q;
   assign bus.done_o      = done_q;
   assign bus.arb_lost_o  = arb_q;
   assign bus.busy_o      = !cmd_ready;
   assign bus.cmd_ready_o = cmd_ready;

endmodule
